// File: rtl/fifo_word_reader.sv
// Purpose : drains the 4-deep 1-bit fifo and packs popped bits (LSB first) into WIDTH-bit words.
// Latency : a popped bit lands in the shift register 1 cycle after its pop edge; the word is valid 1 cycle after the last pop.
// Backpr. : while a finished word waits for word_ready, no pops are issued, so the fifo absorbs the stall.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   fifo_size, fifo_p       fifo non-empty flag and fifo head / last-popped bit
//   fifo_pop, fifo_clear    combinational pop and clear requests to the fifo
//   flush                   synchronous abort: drop the partial or held word and clear the fifo
//   word, word_valid        assembled word and its valid flag (valid/ready handshake)
//   word_ready              downstream accepts the word when valid & ready at posedge
//   bit_count               bits collected so far in the current word
//   timeout_err             one-cycle pulse when a stalled partial word is abandoned
module fifo_word_reader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_size,
  input  logic                       fifo_p,
  output logic                       fifo_pop,
  output logic                       fifo_clear,
  input  logic                       flush,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       timeout_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  // CLR empties the fifo (it has no reset of its own), REQ pops when a bit
  // is available, CAP samples the popped bit, HOLD waits for word_ready.
  typedef enum logic [1:0] {
    CLR  = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shift_q, shift_nxt;
  logic [WIDTH-1:0]  word_nxt;
  logic              valid_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic [IW-1:0]     idle_q, idle_nxt;
  logic              err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLR;
      shift_q     <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
      bit_count   <= '0;
      idle_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_q     <= shift_nxt;
      word        <= word_nxt;
      word_valid  <= valid_nxt;
      bit_count   <= cnt_nxt;
      idle_q      <= idle_nxt;
      timeout_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    word_nxt   = word;
    valid_nxt  = word_valid;
    cnt_nxt    = bit_count;
    idle_nxt   = idle_q;
    err_nxt    = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;

    if (flush && state != CLR) begin
      // Clear now and again in CLR; a held word is dropped, not delivered.
      fifo_clear = 1'b1;
      valid_nxt  = 1'b0;
      state_nxt  = CLR;
    end else begin
      case (state)
        CLR: begin
          fifo_clear = 1'b1;
          shift_nxt  = '0;
          cnt_nxt    = '0;
          idle_nxt   = '0;
          state_nxt  = REQ;
        end

        REQ: begin
          if (fifo_size) begin
            // An arriving bit beats a timeout landing in the same cycle.
            fifo_pop  = 1'b1;
            idle_nxt  = '0;
            state_nxt = CAP;
          end else if (bit_count != '0) begin
            if (idle_q >= IDLE_LAST) begin
              idle_nxt  = IDLE_MAX;
              err_nxt   = 1'b1;
              state_nxt = CLR;
            end else begin
              idle_nxt = idle_q + 1'b1;
            end
          end else begin
            idle_nxt = '0;
          end
        end

        CAP: begin
          // The fifo updated P on the pop edge, so fifo_p is the popped bit.
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_count == CW'(i)) begin
              shift_nxt[i] = fifo_p;
            end
          end
          cnt_nxt = bit_count + 1'b1;
          if (cnt_nxt == CNT_FULL) begin
            word_nxt  = shift_nxt;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            state_nxt = REQ;
          end
        end

        HOLD: begin
          if (word_ready) begin
            valid_nxt = 1'b0;
            state_nxt = REQ;
          end
        end

        default: state_nxt = CLR;
      endcase
    end
  end

endmodule
